// File: rtl/bcd_pkg.sv
// bcd_pkg: shared FSM state type and constant helpers for the binary-to-BCD converter
package bcd_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction
  function automatic int cnt_w(input int bw);
    return $clog2(bw + 1);
  endfunction
endpackage

// File: rtl/bcd_add3_adj.sv
// bcd_add3_adj: one double-dabble nibble adjust, adds 3 when the digit is 5 or more
module bcd_add3_adj (
  input  logic [3:0] i_nib,
  output logic [3:0] o_nib
);
  assign o_nib = i_nib >= 4'd5 ? i_nib + 4'd3 : i_nib;
endmodule

// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: one-bit-per-clock double-dabble converter; define BIN2BCD_BLANK_EN to add the leading-zero blank mask
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin,
  output logic                  busy,
  output logic                  valid,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  ovf
`ifdef BIN2BCD_BLANK_EN
  ,
  output logic [DIGITS-1:0]     blank
`endif
);
  localparam int SW = 4 * (DIGITS + 1);
  localparam int CW = cnt_w(BIN_W);
  localparam logic [63:0] LIMIT = pow10(DIGITS);
  state_t r_state, w_next;
  logic [BIN_W-1:0]    r_sh;
  logic [SW-1:0]       r_scr, w_adj;
  logic [CW-1:0]       r_cnt;
  logic                r_ovf_next, r_valid, r_ovf;
  logic [4*DIGITS-1:0] r_bcd;
  genvar d;
  for (d = 0; d < DIGITS + 1; d++) begin : g_adj
    bcd_add3_adj u_adj (.i_nib(r_scr[4*d +: 4]), .o_nib(w_adj[4*d +: 4]));
  end
  // state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end
  // next state: accept start only in IDLE, leave SHIFT after the last bit, DONE lasts one cycle
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = start ? SHIFT : IDLE;
      SHIFT:   w_next = r_cnt == CW'(1) ? DONE : SHIFT;
      default: w_next = IDLE;
    endcase
  end
`ifdef BIN2BCD_BLANK_EN
  logic [DIGITS-1:0] r_blank, w_blank;
  logic              w_zero;
  // blank a digit when it and every higher output digit are zero; ones digit never blanks
  always_comb begin
    w_blank = '0;
    w_zero  = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      w_zero     = w_zero & (r_scr[4*k +: 4] == 4'd0);
      w_blank[k] = w_zero & ~r_ovf_next;
    end
  end
  assign blank = r_blank;
`endif
  // datapath: capture, add-3/shift per bit, publish result in DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sh       <= '0;
      r_scr      <= '0;
      r_cnt      <= '0;
      r_ovf_next <= 1'b0;
      r_valid    <= 1'b0;
      r_ovf      <= 1'b0;
      r_bcd      <= '0;
`ifdef BIN2BCD_BLANK_EN
      r_blank    <= '0;
`endif
    end else begin
      r_valid <= r_state == DONE;
      case (r_state)
        IDLE: if (start) begin
          r_sh       <= bin;
          r_scr      <= '0;
          r_cnt      <= CW'(BIN_W);
          r_ovf_next <= 64'(bin) >= LIMIT;
        end
        SHIFT: begin
          r_scr <= SW'({w_adj, r_sh[BIN_W-1]});
          r_sh  <= r_sh << 1;
          r_cnt <= r_cnt - CW'(1);
        end
        DONE: begin
          r_bcd <= r_scr[4*DIGITS-1:0];
          r_ovf <= r_ovf_next;
`ifdef BIN2BCD_BLANK_EN
          r_blank <= w_blank;
`endif
        end
        default: ;
      endcase
    end
  end
  assign busy  = r_state == SHIFT;
  assign valid = r_valid;
  assign bcd   = r_bcd;
  assign ovf   = r_ovf;
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb_bin_to_bcd_seq: directed checks of bin_to_bcd_seq across several parameterisations
module tb_bin_to_bcd_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  int n_run = 0;
  int n_fail = 0;
  logic s0 = 1'b0, busy0, val0, ovf0;
  logic [7:0] b0 = '0;
  logic [11:0] bcd0;
  logic s1 = 1'b0, busy1, val1, ovf1;
  logic [7:0] b1 = '0;
  logic [7:0] bcd1;
  logic s2 = 1'b0, busy2, val2, ovf2;
  logic [5:0] b2 = '0;
  logic [11:0] bcd2;
`ifdef BIN2BCD_BLANK_EN
  logic [2:0] blank0;
  logic [1:0] blank1;
  logic [2:0] blank2;
  logic s3 = 1'b0, busy3, val3, ovf3;
  logic [11:0] b3 = '0;
  logic [15:0] bcd3;
  logic [3:0] blank3;
`endif
  bin_to_bcd_seq #(.BIN_W(8), .DIGITS(3)) u0 (
    .clk(clk), .rst(rst), .start(s0), .bin(b0), .busy(busy0), .valid(val0), .bcd(bcd0), .ovf(ovf0)
`ifdef BIN2BCD_BLANK_EN
    , .blank(blank0)
`endif
  );
  bin_to_bcd_seq #(.BIN_W(8), .DIGITS(2)) u1 (
    .clk(clk), .rst(rst), .start(s1), .bin(b1), .busy(busy1), .valid(val1), .bcd(bcd1), .ovf(ovf1)
`ifdef BIN2BCD_BLANK_EN
    , .blank(blank1)
`endif
  );
  bin_to_bcd_seq #(.BIN_W(6), .DIGITS(3)) u2 (
    .clk(clk), .rst(rst), .start(s2), .bin(b2), .busy(busy2), .valid(val2), .bcd(bcd2), .ovf(ovf2)
`ifdef BIN2BCD_BLANK_EN
    , .blank(blank2)
`endif
  );
`ifdef BIN2BCD_BLANK_EN
  bin_to_bcd_seq #(.BIN_W(12), .DIGITS(4)) u3 (
    .clk(clk), .rst(rst), .start(s3), .bin(b3), .busy(busy3), .valid(val3), .bcd(bcd3), .ovf(ovf3),
    .blank(blank3)
  );
`endif
  task automatic conv(input int u, input logic [7:0] v, output logic [11:0] r, output logic o, output int lat);
    @(negedge clk);
    if (u == 0) begin s0 = 1'b1; b0 = v; end
    else begin s1 = 1'b1; b1 = v; end
    @(posedge clk); #1;
    s0 = 1'b0;
    s1 = 1'b0;
    lat = 0;
    for (int c = 1; c <= 20 && lat == 0; c++) begin
      @(posedge clk); #1;
      if ((u == 0 && val0) || (u == 1 && val1)) lat = c;
    end
    r = u == 0 ? bcd0 : {4'd0, bcd1};
    o = u == 0 ? ovf0 : ovf1;
  endtask
  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    n_run++; if (busy0 !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy0); end
    n_run++; if (val0 !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", val0); end
    n_run++; if (bcd0 !== 12'h000) begin n_fail++; $display("FAIL reset_bcd: got %h want 000", bcd0); end
    n_run++; if (ovf0 !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b want 0", ovf0); end
`ifdef BIN2BCD_BLANK_EN
    n_run++; if (blank3 !== 4'b0000) begin n_fail++; $display("FAIL reset_blank: got %b want 0000", blank3); end
`endif
    @(negedge clk);
    rst = 1'b0;
  endtask
  task automatic test_latency;
    int nb, nv, first;
    logic [11:0] r;
    logic o;
    @(negedge clk);
    s2 = 1'b1;
    b2 = 6'd59;
    @(posedge clk); #1;
    s2 = 1'b0;
    b2 = 6'd3;
    nb = busy2 ? 1 : 0;
    nv = 0;
    first = 0;
    r = '0;
    o = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      @(posedge clk); #1;
      if (busy2) nb++;
      if (val2) begin
        nv++;
        if (first == 0) begin first = c; r = bcd2; o = ovf2; end
      end
    end
    n_run++; if (first != 7) begin n_fail++; $display("FAIL lat_valid_cycle: got %0d want 7", first); end
    n_run++; if (nb != 6) begin n_fail++; $display("FAIL lat_busy_cycles: got %0d want 6", nb); end
    n_run++; if (nv != 1) begin n_fail++; $display("FAIL lat_valid_count: got %0d want 1", nv); end
    n_run++; if (r !== 12'h059 || o !== 1'b0) begin n_fail++; $display("FAIL lat_result: got %h/%b want 059/0", r, o); end
  endtask
  task automatic test_overflow;
    logic [7:0] vin [3] = '{8'd255, 8'd99, 8'd100};
    logic [7:0] want [3] = '{8'h55, 8'h99, 8'h00};
    logic wo [3] = '{1'b1, 1'b0, 1'b1};
    logic [11:0] r;
    logic o;
    int lat;
    for (int i = 0; i < 3; i++) begin
      conv(1, vin[i], r, o, lat);
      n_run++;
      if (lat != 9 || r[7:0] !== want[i] || o !== wo[i]) begin
        n_fail++;
        $display("FAIL ovf_%0d: got bcd %h ovf %b lat %0d want %h %b 9", vin[i], r[7:0], o, lat, want[i], wo[i]);
      end
    end
  endtask
  task automatic test_back_to_back;
    int cnt;
    logic [11:0] e;
    @(negedge clk);
    s0 = 1'b1;
    b0 = 8'd0;
    for (int v = 0; v < 256; v++) begin
      cnt = 0;
      do begin
        @(posedge clk); #1;
        cnt++;
      end while (!val0 && cnt < 20);
      e = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
      n_run++;
      if (val0 !== 1'b1 || bcd0 !== e || ovf0 !== 1'b0) begin
        n_fail++;
        $display("FAIL b2b_val_%0d: got valid %b bcd %h ovf %b want 1 %h 0", v, val0, bcd0, ovf0, e);
      end
      n_run++;
      if (cnt != 10) begin n_fail++; $display("FAIL b2b_period_%0d: got %0d want 10", v, cnt); end
      b0 = 8'(v + 1);
    end
    s0 = 1'b0;
    repeat (12) @(posedge clk);
  endtask
  task automatic test_ignore_start;
    int nv;
    logic [11:0] r;
    @(negedge clk);
    s0 = 1'b1;
    b0 = 8'd123;
    @(posedge clk); #1;
    s0 = 1'b0;
    nv = 0;
    r = '0;
    for (int c = 1; c <= 25; c++) begin
      @(negedge clk);
      s0 = (c >= 2 && c <= 4) || c == 9;
      b0 = 8'd45;
      @(posedge clk); #1;
      if (val0) begin nv++; r = bcd0; end
    end
    s0 = 1'b0;
    n_run++; if (nv != 1) begin n_fail++; $display("FAIL ignore_valid_count: got %0d want 1", nv); end
    n_run++; if (r !== 12'h123) begin n_fail++; $display("FAIL ignore_result: got %h want 123", r); end
  endtask
  task automatic test_reset_mid;
    int nv, lat;
    logic [11:0] r;
    logic o;
    @(negedge clk);
    s0 = 1'b1;
    b0 = 8'd200;
    @(posedge clk); #1;
    s0 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    n_run++; if (busy0 !== 1'b0 || val0 !== 1'b0) begin n_fail++; $display("FAIL rstmid_flags: got busy %b valid %b want 0 0", busy0, val0); end
    n_run++; if (bcd0 !== 12'h000 || ovf0 !== 1'b0) begin n_fail++; $display("FAIL rstmid_bcd: got %h/%b want 000/0", bcd0, ovf0); end
    @(negedge clk);
    rst = 1'b0;
    nv = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (val0) nv++;
    end
    n_run++; if (nv != 0) begin n_fail++; $display("FAIL rstmid_stray_valid: got %0d want 0", nv); end
    conv(0, 8'd77, r, o, lat);
    n_run++;
    if (lat != 9 || r !== 12'h077 || o !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_after: got %h/%b lat %0d want 077/0 9", r, o, lat);
    end
  endtask
`ifdef BIN2BCD_BLANK_EN
  task automatic test_blank;
    logic [11:0] vin [3] = '{12'd7, 12'd0, 12'd1205};
    logic [15:0] wb [3] = '{16'h0007, 16'h0000, 16'h1205};
    logic [3:0] wk [3] = '{4'b1110, 4'b1110, 4'b0000};
    int lat;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      s3 = 1'b1;
      b3 = vin[i];
      @(posedge clk); #1;
      s3 = 1'b0;
      lat = 0;
      for (int c = 1; c <= 20 && lat == 0; c++) begin
        @(posedge clk); #1;
        if (val3) lat = c;
      end
      n_run++;
      if (lat != 13 || bcd3 !== wb[i] || blank3 !== wk[i] || ovf3 !== 1'b0) begin
        n_fail++;
        $display("FAIL blank_%0d: got bcd %h blank %b ovf %b lat %0d want %h %b 0 13", vin[i], bcd3, blank3, ovf3, lat, wb[i], wk[i]);
      end
    end
  endtask
`endif
  initial begin
    test_reset;
    test_latency;
    test_overflow;
    test_back_to_back;
    test_ignore_start;
    test_reset_mid;
`ifdef BIN2BCD_BLANK_EN
    test_blank;
`endif
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/bin_to_bcd_seq.md
Name: bin_to_bcd_seq

Overview:
- Sequential, parametrised binary-to-BCD converter using double-dabble: one shift per clock, start/busy/valid handshake.
- Replaces fixed-width divide/modulo conversion; any input width, any digit count, no dividers in the datapath.
- Sits between counter blocks (clock/stopwatch time registers) and the seven-segment display driver.

Parameters:
- BIN_W, 8, width of binary input; legal range 1..32.
- DIGITS, 3, number of BCD digits produced; legal range 1..10.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a conversion; sampled only in IDLE.
- bin  in  BIN_W  binary value; captured on the accepted start cycle.
- busy  out  1  high while a conversion is in progress.
- valid  out  1  single-cycle pulse when bcd/ovf update.
- bcd  out  4*DIGITS  packed result; digit 0 (ones) in [3:0], digit k in [4k+3:4k].
- ovf  out  1  input was >= 10^DIGITS; held with bcd.
- blank  out  DIGITS  leading-zero mask; present only with BIN2BCD_BLANK_EN.

Behaviour:
- Reset: synchronous, active-high. Takes priority over everything, including mid-conversion. All outputs go to 0: busy, valid, bcd, ovf and blank. FSM goes to IDLE and internal scratch registers clear; any in-flight result is discarded.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - start=1 captures bin into the shift register and clears the BCD scratch to 0.
  - Loads bit counter with BIN_W, sets busy=1, goes to SHIFT.
  - ovf_next = (bin >= 10^DIGITS), computed from a package constant at capture.
- SHIFT, each cycle:
  - Every scratch nibble >= 5 gets +3.
  - Then {scratch, shreg} shifts left one bit.
  - Counter decrements. When counter reaches 1 on this cycle, go to DONE.
- DONE (one cycle):
  - bcd <= scratch, ovf <= ovf_next, valid=1, busy=0, return to IDLE.
- Latency: start accepted at edge N -> valid high in cycle N+BIN_W+1. Back-to-back start is accepted in the cycle after valid, giving throughput of one result per BIN_W+2 cycles.
- start while busy or in DONE is ignored, not queued. bin changes after capture have no effect.
- bcd/ovf hold their last value between conversions and change only in the valid cycle.
- Overflow:
  - If the input is >= 10^DIGITS, bcd holds the low DIGITS decimal digits (value mod 10^DIGITS) and ovf=1.
  - Scratch is internally sized DIGITS+1 nibbles so the truncation is exact.
- Widths: the add-3 adjust is applied nibble-wise. No nibble ever exceeds 9 at DONE.
- bin=0 yields all-zero bcd, ovf=0.
- BIN_W=1 is legal: one SHIFT cycle.

Optional Feature:
- Macro: BIN2BCD_BLANK_EN.
- Defined:
  - Adds the blank output. blank[k]=1 when digit k and all higher digits are 0, for k >= 1. blank[0] is always 0, so a zero value shows a single "0".
  - Updated in the valid cycle together with bcd. Reset to 0.
  - If ovf=1, blank is all 0.
- Undefined: the blank port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package bcd_pkg holds:
  - Constant function pow10(n), used for the ovf threshold.
  - FSM state enum {IDLE, SHIFT, DONE}.
  - Localparam helper for counter width: clog2(BIN_W+1).
- One sub-module: bcd_add3_adj, a combinational single-nibble conditional +3 (in >= 5 -> in+3). Instantiated DIGITS+1 times in a generate loop.

Test Plan:
- BIN_W=6, DIGITS=3, bin=59, start pulse -> valid exactly 7 cycles later; bcd=0x059, ovf=0; busy high for 6 cycles.
- BIN_W=8, DIGITS=2, bin=255 -> bcd=0x55, ovf=1. Then bin=99 -> bcd=0x99, ovf=0.
- Exhaustive BIN_W=8, DIGITS=3, values 0..255 back-to-back (start asserted the cycle after each valid) -> every result matches the reference decimal; one result per 10 cycles.
- start re-asserted mid-conversion with a different bin -> ignored; result reflects the first bin; no extra valid.
- rst asserted at SHIFT cycle 3 -> next cycle busy=0, valid=0, bcd=0; a subsequent start converts correctly.
- With BIN2BCD_BLANK_EN, DIGITS=4: bin=7 -> blank=4'b1110; bin=0 -> blank=4'b1110, bcd=0; bin=1205 -> blank=4'b0000.
